uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Parametrised UART transmit serializer: the next generation of the transmitter's frame generator and shift register. It accepts words through a valid/ready handshake into a one-entry holding buffer and computes parity internally. It emits frames of configurable data width, bit order and stop-bit count on `data_tx`, one bit per `baud_clk` cycle. Frames go back-to-back with no idle gap when the buffer is refilled in time. It sits between the transmit-side host logic and the UART TX pin, clocked by the BaudGen output.

## Interface
- `DATA_WIDTH`, 8, data bits per frame; legal range 5–9.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.
- `MSB_FIRST`, 0, bit order: 0 sends data LSB first, 1 sends MSB first.

- `baud_clk`  in  1  the only clock, one bit time per cycle. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `parity_type`  in  2  00/11 no parity; 01 odd; 10 even. Sampled at word acceptance.
- `data_in`  in  DATA_WIDTH  word to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  holding buffer empty; the word transfers when `data_valid && data_ready` at a `baud_clk` edge.
- `data_tx`  out  1  serial output, registered, idles high.
- `active_flag`  out  1  high while any frame bit (start through last stop) is on `data_tx`.
- `done_flag`  out  1  one-cycle pulse marking the last stop bit of each frame.

## Operation
- Frame contents, in order:
  - start bit 0;
  - DATA_WIDTH data bits, in the order set by MSB_FIRST;
  - parity bit, only if parity is enabled;
  - STOP_BITS bits of 1.
- Frame length L = 1 + DATA_WIDTH + P + STOP_BITS, where P = 1 if parity is enabled, else 0.
- Parity is computed on the accepted word:
  - odd mode: the total count of ones in data plus parity is odd;
  - even mode: that total is even.
- The holding buffer stores `{data_in, parity enable, parity bit}` and a `hold_valid` flag. `data_ready = ~hold_valid`, driven from a register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `data_tx`=1. On a cycle with `hold_valid`, move the buffer into the shift register, clear `hold_valid`, and go to START.
  - START: `data_tx`=0 for 1 cycle, then DATA.
  - DATA: one bit per cycle for DATA_WIDTH cycles, tracked by a bit counter of width $clog2(DATA_WIDTH+1). Then go to PARITY if parity is enabled, else STOP.
  - PARITY: 1 cycle, then STOP.
  - STOP: `data_tx`=1 for STOP_BITS cycles. On the last stop cycle:
    - if `hold_valid`, load the buffer and go directly to START, so the next cycle is a start bit;
    - otherwise go to IDLE.
- `parity_type` and `data_in` changes after acceptance have no effect on the frame in flight or on the buffered word.
- The buffer can accept a new word while a frame is shifting, so sustained throughput is one word per L cycles.

## Timing
- Reset values, applied at the first edge with `reset`=1:
  - `data_tx`=1, `active_flag`=0, `done_flag`=0, `data_ready`=1;
  - FSM in IDLE, `hold_valid`=0.
- Reset asserted mid-frame aborts the frame and discards any buffered word. `data_tx` is 1 after that edge. Handshakes on edges where `reset`=1 are ignored.
- Latency from an idle block:
  - word accepted at edge N;
  - START entered at edge N+1, so the start bit is on `data_tx` for the cycle after edge N+1;
  - the last stop bit is on `data_tx` L cycles after edge N+1.
- `data_ready` falls after the accepting edge. It rises after the edge that moves the buffer into the shifter. Accept and drain never occur on the same edge.
- `active_flag` is registered and aligned with `data_tx`. It stays continuously high across back-to-back frames.
- `done_flag` is high for exactly the cycle carrying the final stop bit, once per frame.

## Structure
- Shared package `uart_pkg`:
  - `parity_type` encodings (PARITY_NONE0, PARITY_ODD, PARITY_EVEN, PARITY_NONE1);
  - FSM state enumeration;
  - legal-range constants for DATA_WIDTH and STOP_BITS.
  - The receiver block reuses the same encodings.
- One sub-module, `uart_parity_gen`: combinational XOR-reduce of a DATA_WIDTH word plus the odd/even select. Shared with the RX parity checker.
- Out-of-range parameters stop elaboration with `$error` through a generate check.

## Test plan
- DATA_WIDTH=8, no parity, STOP_BITS=1, send 0xA5 → `data_tx` reads 0,1,0,1,0,0,1,0,1,1 over 10 cycles, starting the cycle after edge N+1. `done_flag` pulses on the last bit, then `data_tx` idles at 1.
- Same 0xA5 with parity_type=10, then with 01 → parity bit 0, then 1. Each frame is 11 cycles.
- Back-to-back 0x00 then 0xFF, with the second `data_valid` held until accepted → 20 contiguous frame cycles with no idle bit between frames. `active_flag` stays high throughout and `done_flag` pulses twice.
- MSB_FIRST=1, DATA_WIDTH=7, STOP_BITS=2, send 0x41 → 0,1,0,0,0,0,0,1,1,1. `data_ready` is low from acceptance until the load edge.
- Assert `reset` for 1 cycle during data bit 3, with a buffered word pending → `data_tx`=1, `active_flag`=0, `data_ready`=1 after the edge. No further frame is emitted.
- Change `parity_type` and `data_in` mid-frame → the in-flight frame and the buffered frame are both unchanged. Check the parity bit against a reference model.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, serializer FSM states and legal parameter ranges.
// The receive side uses the same parity encodings.
package uart_pkg;

   localparam int unsigned DATA_WIDTH_MIN = 5;
   localparam int unsigned DATA_WIDTH_MAX = 9;
   localparam int unsigned STOP_BITS_MIN  = 1;
   localparam int unsigned STOP_BITS_MAX  = 2;

   localparam logic [1:0] PARITY_NONE0 = 2'b00;
   localparam logic [1:0] PARITY_ODD   = 2'b01;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_NONE1 = 2'b11;

   localparam int unsigned STATE_W = 3;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // True when the encoding carries a parity bit in the frame.
   function automatic logic parity_enabled(input logic [1:0] ptype);
      logic en;
      case (ptype)
         PARITY_ODD, PARITY_EVEN:     en = 1'b1;
         PARITY_NONE0, PARITY_NONE1:  en = 1'b0;
         default:                     en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit for a DATA_WIDTH word: odd_sel=1 makes data+parity odd, otherwise even.
// Shared between the TX serializer and the RX parity checker.
module uart_parity_gen #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  odd_sel,
   output logic                  parity_c
);

   assign parity_c = (^data) ^ odd_sel;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding buffer behind a valid/ready handshake feeding a
// frame FSM that shifts start, data, optional parity and stop bits out on data_tx.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic                  baud_clk,
   input  logic                  reset,
   input  logic [1:0]            parity_type,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  data_tx,
   output logic                  active_flag,
   output logic                  done_flag
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
      $error("uart_tx_serializer: DATA_WIDTH %0d outside 5..9", DATA_WIDTH);
   end
   if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS %0d must be 1 or 2", STOP_BITS);
   end

   logic [STATE_W-1:0]    state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_par_en_q, hold_par_en_d;
   logic                  hold_par_bit_q, hold_par_bit_d;
   logic                  data_ready_q, data_ready_d;
   logic                  data_tx_q, data_tx_d;
   logic                  active_q, active_d;
   logic                  done_q, done_d;

   logic                  in_parity_c;
   logic                  accept_c;
   logic                  load_c;
   logic [DATA_WIDTH-1:0] load_word_c;

   uart_parity_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_gen (
      .data     (data_in),
      .odd_sel  (parity_type == PARITY_ODD),
      .parity_c (in_parity_c)
   );

   // The shifter always emits bit 0 first, so MSB-first words are reversed on load.
   always_comb begin
      load_word_c = hold_data_q;
      if (MSB_FIRST) begin
         for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            load_word_c[i] = hold_data_q[int'(DATA_WIDTH) - 1 - i];
         end
      end
   end

   // Next-state logic; outputs are derived from the state being entered so they register
   // aligned with the bit on the line.
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      stop_cnt_d     = stop_cnt_q;
      par_en_d       = par_en_q;
      par_bit_d      = par_bit_q;
      hold_valid_d   = hold_valid_q;
      hold_data_d    = hold_data_q;
      hold_par_en_d  = hold_par_en_q;
      hold_par_bit_d = hold_par_bit_q;
      load_c         = 1'b0;
      accept_c       = data_valid && data_ready_q;

      case (state_q)
         ST_IDLE: begin
            if (hold_valid_q) begin
               load_c = 1'b1;
            end
         end
         ST_START: begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
         end
         ST_DATA: begin
            if (bit_cnt_q == LAST_BIT) begin
               state_d    = par_en_q ? ST_PARITY : ST_STOP;
               stop_cnt_d = 1'b0;
            end else begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         ST_PARITY: begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
         end
         ST_STOP: begin
            if (stop_cnt_q == LAST_STOP) begin
               if (hold_valid_q) begin
                  load_c = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_c) begin
         state_d      = ST_START;
         shift_d      = load_word_c;
         par_en_d     = hold_par_en_q;
         par_bit_d    = hold_par_bit_q;
         hold_valid_d = 1'b0;
      end

      // Accept needs an empty buffer and load needs a full one, so they never coincide.
      if (accept_c) begin
         hold_valid_d   = 1'b1;
         hold_data_d    = data_in;
         hold_par_en_d  = parity_enabled(parity_type);
         hold_par_bit_d = in_parity_c;
      end

      data_ready_d = ~hold_valid_d;

      case (state_d)
         ST_START:  data_tx_d = 1'b0;
         ST_DATA:   data_tx_d = shift_d[0];
         ST_PARITY: data_tx_d = par_bit_d;
         default:   data_tx_d = 1'b1;
      endcase
      active_d = (state_d != ST_IDLE);
      done_d   = (state_d == ST_STOP) && (stop_cnt_d == LAST_STOP);
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         stop_cnt_q     <= 1'b0;
         par_en_q       <= 1'b0;
         par_bit_q      <= 1'b0;
         hold_valid_q   <= 1'b0;
         hold_data_q    <= '0;
         hold_par_en_q  <= 1'b0;
         hold_par_bit_q <= 1'b0;
         data_ready_q   <= 1'b1;
         data_tx_q      <= 1'b1;
         active_q       <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         stop_cnt_q     <= stop_cnt_d;
         par_en_q       <= par_en_d;
         par_bit_q      <= par_bit_d;
         hold_valid_q   <= hold_valid_d;
         hold_data_q    <= hold_data_d;
         hold_par_en_q  <= hold_par_en_d;
         hold_par_bit_q <= hold_par_bit_d;
         data_ready_q   <= data_ready_d;
         data_tx_q      <= data_tx_d;
         active_q       <= active_d;
         done_q         <= done_d;
      end
   end

   assign data_ready  = data_ready_q;
   assign data_tx     = data_tx_q;
   assign active_flag = active_q;
   assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two configurations (8N1 LSB-first, 7-bit MSB-first 2 stop)
// checked each cycle against a frame-level line model, plus literal bit-stream expectations.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   logic       clk;
   logic       rst_a, vld_a, rdy_a, tx_a, act_a, done_a;
   logic [1:0] pt_a;
   logic [7:0] din_a;
   logic       rst_b, vld_b, rdy_b, tx_b, act_b, done_b;
   logic [1:0] pt_b;
   logic [6:0] din_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1), .MSB_FIRST(1'b0)) dut_a (
      .baud_clk(clk), .reset(rst_a), .parity_type(pt_a), .data_in(din_a),
      .data_valid(vld_a), .data_ready(rdy_a), .data_tx(tx_a),
      .active_flag(act_a), .done_flag(done_a));

   uart_tx_serializer #(.DATA_WIDTH(7), .STOP_BITS(2), .MSB_FIRST(1'b1)) dut_b (
      .baud_clk(clk), .reset(rst_b), .parity_type(pt_b), .data_in(din_b),
      .data_valid(vld_b), .data_ready(rdy_b), .data_tx(tx_b),
      .active_flag(act_b), .done_flag(done_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame-level model: per instance, the frame on the line (word + position) and a pending word.
   function automatic int dw_of(input int i);  return (i == 0) ? 8 : 7; endfunction
   function automatic bit msb_of(input int i); return (i == 1);         endfunction
   function automatic int sb_of(input int i);  return (i == 0) ? 1 : 2; endfunction
   function automatic bit pen(input logic [1:0] pt);
      return (pt == PARITY_ODD) || (pt == PARITY_EVEN);
   endfunction
   function automatic int frame_len(input logic [1:0] pt, input int i);
      return 1 + dw_of(i) + (pen(pt) ? 1 : 0) + sb_of(i);
   endfunction
   function automatic logic frame_bit(input logic [8:0] d, input logic [1:0] pt, input int i,
                                      input int idx);
      int dw;
      int ones;
      dw   = dw_of(i);
      ones = $countones(d);
      if (idx == 0) return 1'b0;
      if (idx <= dw) return msb_of(i) ? d[dw - idx] : d[idx - 1];
      if (pen(pt) && idx == dw + 1) begin
         if (pt == PARITY_ODD) return (ones % 2) == 0;
         return (ones % 2) == 1;
      end
      return 1'b1;
   endfunction

   bit         m_act [2];
   int         m_pos [2];
   logic [8:0] m_ld  [2];
   logic [1:0] m_lpt [2];
   bit         m_hold[2];
   logic [8:0] m_hd  [2];
   logic [1:0] m_hpt [2];

   task automatic model_step(input int i, input logic r, input logic v, input logic [8:0] d,
                             input logic [1:0] pt);
      bit acc;
      acc = v && !m_hold[i];
      if (r) begin
         m_act[i]  = 0;
         m_hold[i] = 0;
         return;
      end
      if (m_act[i]) begin
         m_pos[i]++;
         if (m_pos[i] >= frame_len(m_lpt[i], i)) m_act[i] = 0;
      end
      if (!m_act[i] && m_hold[i]) begin
         m_act[i]  = 1;
         m_pos[i]  = 0;
         m_ld[i]   = m_hd[i];
         m_lpt[i]  = m_hpt[i];
         m_hold[i] = 0;
      end
      if (acc) begin
         m_hold[i] = 1;
         m_hd[i]   = d;
         m_hpt[i]  = pt;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_pos[i] = 0; m_hold[i] = 0;
         m_ld[i] = '0; m_lpt[i] = '0; m_hd[i] = '0; m_hpt[i] = '0;
      end
      forever begin
         @(posedge clk);
         model_step(0, rst_a, vld_a, {1'b0, din_a}, pt_a);
         model_step(1, rst_b, vld_b, {2'b00, din_b}, pt_b);
      end
   end

   task automatic chk_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
      end
   endtask

   task automatic chk_str(input string name, input string got, input string exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%s exp=%s", name, got, exp);
      end
   endtask

   task automatic compare_inst(input int i, input string tag, input logic tx, input logic act,
                               input logic dn, input logic rdy);
      logic e_tx;
      logic e_dn;
      e_tx = m_act[i] ? frame_bit(m_ld[i], m_lpt[i], i, m_pos[i]) : 1'b1;
      e_dn = m_act[i] && (m_pos[i] == frame_len(m_lpt[i], i) - 1);
      chk_bit({tag, ".data_tx"}, tx, e_tx);
      chk_bit({tag, ".active_flag"}, act, m_act[i]);
      chk_bit({tag, ".done_flag"}, dn, e_dn);
      chk_bit({tag, ".data_ready"}, rdy, !m_hold[i]);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            compare_inst(0, "model_a", tx_a, act_a, done_a, rdy_a);
            compare_inst(1, "model_b", tx_b, act_b, done_b, rdy_b);
         end
      end
   end

   // Offer a word and hold data_valid until it is taken; afterwards scramble the inputs.
   task automatic send(input int i, input logic [8:0] d, input logic [1:0] pt);
      bit took;
      took = 0;
      if (i == 0) begin vld_a = 1'b1; din_a = d[7:0]; pt_a = pt; end
      else        begin vld_b = 1'b1; din_b = d[6:0]; pt_b = pt; end
      for (int k = 0; k < 100 && !took; k++) begin
         @(negedge clk);
         if ((i == 0) ? rdy_a : rdy_b) took = 1;
      end
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL send_timeout inst=%0d got=no_accept exp=accept", i);
      end
      @(posedge clk);
      #1;
      if (i == 0) begin vld_a = 1'b0; din_a = ~d[7:0]; pt_a = pt ^ 2'b11; end
      else        begin vld_b = 1'b0; din_b = ~d[6:0]; pt_b = pt ^ 2'b11; end
   endtask

   task automatic capture(input int i, input int n, output string txs, output string dns,
                          output string acs);
      txs = ""; dns = ""; acs = "";
      @(posedge clk);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         txs = $sformatf("%s%0d", txs, (i == 0) ? tx_a : tx_b);
         dns = $sformatf("%s%0d", dns, (i == 0) ? done_a : done_b);
         acs = $sformatf("%s%0d", acs, (i == 0) ? act_a : act_b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   string s_tx, s_dn, s_ac;

   initial begin
      rst_a = 1'b1; vld_a = 1'b0; din_a = '0; pt_a = PARITY_NONE0;
      rst_b = 1'b1; vld_b = 1'b0; din_b = '0; pt_b = PARITY_NONE0;
      @(posedge clk);
      chk_en = 1;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk_bit("reset_tx", tx_a, 1'b1);
      chk_bit("reset_active", act_a, 1'b0);
      chk_bit("reset_done", done_a, 1'b0);
      chk_bit("reset_ready", rdy_a, 1'b1);
      chk_bit("reset_ready_b", rdy_b, 1'b1);
      idle(1);

      // 0xA5, 8N1
      send(0, 9'h0A5, PARITY_NONE0);
      capture(0, 10, s_tx, s_dn, s_ac);
      chk_str("a5_none_tx", s_tx, "0101001011");
      chk_str("a5_none_done", s_dn, "0000000001");
      @(negedge clk);
      chk_bit("a5_idle_tx", tx_a, 1'b1);
      chk_bit("a5_idle_active", act_a, 1'b0);
      idle(2);

      send(0, 9'h0A5, PARITY_EVEN);
      capture(0, 11, s_tx, s_dn, s_ac);
      chk_str("a5_even_tx", s_tx, "01010010101");
      chk_str("a5_even_done", s_dn, "00000000001");
      idle(2);

      send(0, 9'h0A5, PARITY_ODD);
      capture(0, 11, s_tx, s_dn, s_ac);
      chk_str("a5_odd_tx", s_tx, "01010010111");
      idle(2);

      // Back-to-back 0x00 then 0xFF
      send(0, 9'h000, PARITY_NONE1);
      fork
         send(0, 9'h0FF, PARITY_NONE0);
         capture(0, 20, s_tx, s_dn, s_ac);
      join
      chk_str("b2b_tx", s_tx, "00000000010111111111");
      chk_str("b2b_done", s_dn, "00000000010000000001");
      chk_str("b2b_active", s_ac, "11111111111111111111");
      idle(3);

      // 7-bit MSB-first, two stop bits
      send(1, 9'h041, PARITY_NONE0);
      chk_bit("b_ready_after_accept", rdy_b, 1'b0);
      capture(1, 10, s_tx, s_dn, s_ac);
      chk_str("b_41_tx", s_tx, "0100000111");
      chk_str("b_41_done", s_dn, "0000000001");
      idle(3);

      // Inputs scrambled after each acceptance must not affect either frame
      send(0, 9'h05A, PARITY_ODD);
      fork
         send(0, 9'h0C3, PARITY_EVEN);
         capture(0, 22, s_tx, s_dn, s_ac);
      join
      chk_str("midframe_tx", s_tx, "0010110101101100001101");
      chk_str("midframe_done", s_dn, "0000000000100000000001");
      idle(3);

      // Reset during data bit 3 with a word buffered
      send(0, 9'h03C, PARITY_NONE0);
      send(0, 9'h081, PARITY_NONE0);
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      @(negedge clk);
      chk_bit("midreset_tx", tx_a, 1'b1);
      chk_bit("midreset_active", act_a, 1'b0);
      chk_bit("midreset_ready", rdy_a, 1'b1);
      capture(0, 15, s_tx, s_dn, s_ac);
      chk_str("post_reset_tx", s_tx, "111111111111111");
      chk_str("post_reset_active", s_ac, "000000000000000");
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
